ring_sequence_decoder: RTL
==========================

# ring_sequence_decoder

Receive-side companion to the one-hot ring counter. Samples a WIDTH-bit one-hot ring pattern, locks onto a legal rotation sequence, and outputs the binary index of the hot bit. Flags sequence errors, wrap-arounds and lock status. Used wherever a ring-counter phase bus must be decoded or checked, such as phase selects and round-robin slot IDs.

## Interface
- WIDTH, 4: ring length in bits; must be ≥ 2.
- SHIFT_LEFT, 1: 1 = legal next state is the rotate-left of the current pattern (bit i → bit i+1, MSB → bit 0); 0 = rotate-right.
- LOCK_CNT, 4: consecutive legal transitions required to declare lock; must be ≥ 1.
- CNT_W, 8: width of the error counter.
- IW, $clog2(WIDTH): index width (derived, not overridden).

Ports (clock and reset first):
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  sample enable; q_in is evaluated only on edges where en=1.
- q_in  in  WIDTH  ring pattern under decode.
- err_clr  in  1  synchronous clear of err_count.
- idx  out  IW  binary position of the hot bit in the last accepted locked sample.
- idx_valid  out  1  high while locked and idx is current.
- locked  out  1  high in the LOCKED state.
- wrap  out  1  one-cycle pulse on a locked legal transition that wraps the ends (MSB→bit 0 when SHIFT_LEFT=1; bit 0→MSB otherwise).
- err  out  1  one-cycle pulse on an illegal sample while locked.
- err_count  out  CNT_W  saturating count of err pulses.

## Operation
- onehot(x): exactly one bit of x is set. All-zero is illegal.
- next(p): rotate of p by one position in the SHIFT_LEFT direction.
- Internal registers:
  - prev: last accepted pattern.
  - run: legal-transition counter, 0..LOCK_CNT.
- States: UNLOCKED, LOCKING, LOCKED. The reset state is UNLOCKED.
- UNLOCKED, en=1:
  - If onehot(q_in): prev←q_in, run←0, go to LOCKING.
  - Otherwise stay in UNLOCKED. No err is raised.
- LOCKING, en=1:
  - If q_in==next(prev): prev←q_in, run←run+1. When run reaches LOCK_CNT, go to LOCKED and set idx←index(q_in), idx_valid←1.
  - Else if onehot(q_in): prev←q_in, run←0, stay in LOCKING.
  - Else go to UNLOCKED. No err is raised.
- LOCKED, en=1:
  - If q_in==next(prev): prev←q_in, idx←index(q_in), idx_valid stays 1, and wrap pulses if the transition crossed the ends.
  - Otherwise: err pulse, err_count+1 (saturating at 2^CNT_W−1), locked←0, idx_valid←0, go to UNLOCKED.
  - idx holds its last value after loss of lock.
- Repeated sample while LOCKED (q_in==prev, i.e. the source stalled without en gating): this is illegal and raises err.
- en=0: no state, prev, run or idx change. wrap and err are 0. Levels hold.
- err_clr=1: err_count←0. If it coincides with an err event, clear wins and the count is 0; the err pulse itself still fires.
- Saturation: err_count never rolls over. err still pulses when the count is saturated.

## Timing
- All outputs are registered. Latency is 1 cycle: an effect of q_in sampled at edge N is visible after edge N.
- Minimum time to lock is LOCK_CNT+1 enabled samples: one to enter LOCKING, then LOCK_CNT legal transitions.
- locked and idx_valid rise on the same edge. On error, both fall on the same edge as the err pulse.
- wrap and err are single-cycle pulses and are mutually exclusive.
- Reset values: idx=0, idx_valid=0, locked=0, wrap=0, err=0, err_count=0, prev=0, run=0, state UNLOCKED.
- reset overrides en and err_clr. A reset mid-lock drops locked on the next edge, and relock requires the full LOCK_CNT+1 sequence.
- q_in must be stable around the clk edge (synchronous source). There is no internal synchronizer.

## Test plan
Defaults throughout: WIDTH=4, SHIFT_LEFT=1, LOCK_CNT=4.

1. **Reset.** Hold reset for 2 cycles with q_in=0001, en=1. Required: all outputs 0 and state UNLOCKED. After release, stream 0001,0010,0100,1000,0001: locked=1 and idx_valid=1 after the 5th edge, with idx=0.
2. **Locked decode and wrap.** Continue the stream 0010,0100,1000,0001. Required: idx=1,2,3,0 on consecutive cycles. wrap pulses exactly once, with the 0001 sample. err stays 0.
3. **Error while locked.** While locked with prev=0010, apply 1000. Required: err=1 for 1 cycle, err_count=1, locked=0, idx_valid=0, idx holds 1. Then apply 0000,0011. Required: still UNLOCKED, no further err.
4. **Lock-acquire restart.** Apply 0001,0010,1000,0001,0010,0100,1000. Required: the run restarts at 1000; locked rises only after the 7th sample, with idx=3.
5. **Enable gating and stall.** While locked, drop en for 3 cycles with q_in=1111. Required: no output change. Then raise en with q_in equal to prev. Required: err pulse.
6. **Saturation, clear priority, reset mid-lock.** Use CNT_W=2 and force 5 errors. Required: err_count saturates at 3 and err pulses 5 times. Assert err_clr together with the next error: err pulses and err_count=0. Assert reset while locked: locked=0 on the next edge.

Source files
------------

// File: rtl/ring_sequence_decoder.sv
// Receive-side decoder for a one-hot ring counter bus: locks onto the legal
// rotation sequence, reports the hot-bit index and flags wraps and sequence errors.
module ring_sequence_decoder #(
    parameter int WIDTH      = 4,
    parameter int SHIFT_LEFT = 1,
    parameter int LOCK_CNT   = 4,
    parameter int CNT_W      = 8,
    localparam int IW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] q_in,
    input  logic             err_clr,
    output logic [IW-1:0]    idx,
    output logic             idx_valid,
    output logic             locked,
    output logic             wrap,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam logic [RW-1:0]    RUN_LAST = RW'(LOCK_CNT - 1);
    localparam logic [RW-1:0]    RUN_FULL = RW'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] prev_r;
    logic [RW-1:0]    run_r;

    logic [WIDTH-1:0] nxt_s;
    logic             legal_s;
    logic             hot_s;
    logic             cross_s;
    logic             err_event_s;
    logic [IW-1:0]    hit_idx_s;

    function automatic logic onehot(input logic [WIDTH-1:0] x);
        int ones;
        ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + int'(x[i]);
        end
        return (ones == 1);
    endfunction

    function automatic logic [WIDTH-1:0] next_pat(input logic [WIDTH-1:0] p);
        if (SHIFT_LEFT != 0) begin
            return {p[WIDTH-2:0], p[WIDTH-1]};
        end else begin
            return {p[0], p[WIDTH-1:1]};
        end
    endfunction

    function automatic logic [IW-1:0] index_of(input logic [WIDTH-1:0] x);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) begin
                r = IW'(i);
            end
        end
        return r;
    endfunction

    // The wrap crosses the ends when the hot bit leaves the edge it rotates out of.
    assign nxt_s       = next_pat(prev_r);
    assign legal_s     = (q_in == nxt_s);
    assign hot_s       = onehot(q_in);
    assign hit_idx_s   = index_of(q_in);
    assign cross_s     = (SHIFT_LEFT != 0) ? prev_r[WIDTH-1] : prev_r[0];
    assign err_event_s = en & (state_r == LOCKED) & ~legal_s;

    // Lock FSM, pattern history and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= UNLOCKED;
            prev_r    <= '0;
            run_r     <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
            locked    <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
            if (err_clr) begin
                err_count <= '0;
            end else if (err_event_s && (err_count != CNT_MAX)) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (en) begin
                case (state_r)
                    UNLOCKED: begin
                        if (hot_s) begin
                            prev_r  <= q_in;
                            run_r   <= '0;
                            state_r <= LOCKING;
                        end
                    end
                    LOCKING: begin
                        if (legal_s) begin
                            prev_r <= q_in;
                            if (run_r == RUN_LAST) begin
                                run_r     <= RUN_FULL;
                                state_r   <= LOCKED;
                                idx       <= hit_idx_s;
                                idx_valid <= 1'b1;
                                locked    <= 1'b1;
                            end else begin
                                run_r <= run_r + RW'(1);
                            end
                        end else if (hot_s) begin
                            prev_r <= q_in;
                            run_r  <= '0;
                        end else begin
                            state_r <= UNLOCKED;
                        end
                    end
                    LOCKED: begin
                        if (legal_s) begin
                            prev_r <= q_in;
                            idx    <= hit_idx_s;
                            wrap   <= cross_s;
                        end else begin
                            err       <= 1'b1;
                            locked    <= 1'b0;
                            idx_valid <= 1'b0;
                            state_r   <= UNLOCKED;
                        end
                    end
                    default: begin
                        state_r <= UNLOCKED;
                    end
                endcase
            end
        end
    end

endmodule
